// File: rtl/cfi_event_queue.sv
// CFI event queue: classifies committed calls/returns and buffers them
// in order for the CFI checker, with commit back-pressure and sticky overflow.

package cfi_pkg;

    localparam int unsigned VLEN = 32;

    typedef enum logic [3:0] {
        FU_NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef enum logic [7:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        JAL,
        JALR,
        BEQ,
        BNE
    } fu_op_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        fu_t             fu;
        fu_op_t          op;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        logic            is_compressed;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_CALL = 2'b01,
        EVT_RET  = 2'b10
    } evt_kind_t;

    typedef struct packed {
        evt_kind_t       kind;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] addr;
    } cfi_evt_t;

endpackage

module cfi_event_queue
    import cfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_sbe_i,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]      commit_target_i,
    output logic                                      cfi_wait_o,
    output logic                                      evt_valid_o,
    input  logic                                      evt_ready_i,
    output logic [1:0]                                evt_kind_o,
    output logic [VLEN-1:0]                           evt_pc_o,
    output logic [VLEN-1:0]                           evt_addr_o,
    output logic                                      overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PORTS_C = CW'(NR_COMMIT_PORTS);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    cfi_evt_t      mem_q [DEPTH];

    cfi_evt_t      port_evt [NR_COMMIT_PORTS];
    logic          port_hit [NR_COMMIT_PORTS];
    logic          wr_en    [NR_COMMIT_PORTS];
    logic [PW-1:0] wr_slot  [NR_COMMIT_PORTS];

    logic [CW-1:0] free_slots;
    logic [CW-1:0] push_cnt;
    logic          drop;
    logic          pop;
    cfi_evt_t      head;

    // Per-port call/return classification
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            logic ctrl;
            logic link_rd;
            logic link_rs1;
            logic is_call;
            logic is_ret;
            logic [VLEN-1:0] step;

            ctrl     = commit_ack_i[i] &&
                       (commit_sbe_i[i].fu == CTRL_FLOW);
            link_rd  = (commit_sbe_i[i].rd == 5'd1) ||
                       (commit_sbe_i[i].rd == 5'd5);
            link_rs1 = (commit_sbe_i[i].rs1 == 5'd1) ||
                       (commit_sbe_i[i].rs1 == 5'd5);
            is_call  = ctrl && link_rd &&
                       ((commit_sbe_i[i].op == JAL) ||
                        (commit_sbe_i[i].op == JALR));
            is_ret   = ctrl && !is_call && link_rs1 &&
                       (commit_sbe_i[i].op == JALR) &&
                       (commit_sbe_i[i].rd == 5'd0);
            step     = commit_sbe_i[i].is_compressed ?
                       VLEN'(2) : VLEN'(4);

            port_hit[i]      = is_call || is_ret;
            port_evt[i].pc   = commit_sbe_i[i].pc;
            port_evt[i].kind = EVT_NONE;
            port_evt[i].addr = commit_target_i[i];
            if (is_call) begin
                port_evt[i].kind = EVT_CALL;
                port_evt[i].addr = commit_sbe_i[i].pc + step;
            end else if (is_ret) begin
                port_evt[i].kind = EVT_RET;
            end
        end
    end

    assign free_slots = DEPTH_C - count_q;

    // Lower ports claim free slots first; the remainder is dropped
    always_comb begin
        logic [CW-1:0] n;
        n    = '0;
        drop = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            wr_en[i]   = 1'b0;
            wr_slot[i] = wr_ptr_q + PW'(n);
            if (port_hit[i]) begin
                if (n < free_slots) begin
                    wr_en[i] = 1'b1;
                    n        = n + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        push_cnt = n;
    end

    assign evt_valid_o = (count_q != '0);
    assign pop         = evt_valid_o && evt_ready_i;
    assign head        = mem_q[rd_ptr_q];
    assign cfi_wait_o  = free_slots < PORTS_C;
    assign overflow_o  = overflow_q;

    always_comb begin
        evt_kind_o = 2'b00;
        evt_pc_o   = '0;
        evt_addr_o = '0;
        if (evt_valid_o) begin
            evt_kind_o = head.kind;
            evt_pc_o   = head.pc;
            evt_addr_o = head.addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + PW'(push_cnt);
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            count_q    <= count_q + push_cnt - CW'(pop);
            overflow_q <= overflow_q | drop;
        end
    end

    // Payload storage carries no reset; validity comes from count_q
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_slot[i]] <= port_evt[i];
            end
        end
    end

endmodule

// File: tb/tb_cfi_event_queue.sv
// Directed and randomised bench for cfi_event_queue with an
// in-order scoreboard of expected events.

module tb_cfi_event_queue;
    import cfi_pkg::*;

    localparam int P = 2;
    localparam int D = 8;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    scoreboard_entry_t [P-1:0] sbe;
    logic [P-1:0] ack;
    logic [P-1:0][VLEN-1:0] target;
    logic wait_o;
    logic valid;
    logic ready;
    logic [1:0] kind;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] addr;
    logic ovf;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cfi_event_queue #(
        .NR_COMMIT_PORTS(P),
        .DEPTH(D)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .commit_sbe_i(sbe),
        .commit_ack_i(ack),
        .commit_target_i(target),
        .cfi_wait_o(wait_o),
        .evt_valid_o(valid),
        .evt_ready_i(ready),
        .evt_kind_o(kind),
        .evt_pc_o(pc),
        .evt_addr_o(addr),
        .overflow_o(ovf)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ack = '0;
        sbe = '0;
        target = '0;
    endtask

    task automatic drive(int p, fu_t fu, fu_op_t op, logic [4:0] rd,
                         logic [4:0] rs1, logic [31:0] a_pc,
                         logic comp, logic [31:0] tgt, logic a);
        sbe[p].pc = a_pc;
        sbe[p].fu = fu;
        sbe[p].op = op;
        sbe[p].rd = rd;
        sbe[p].rs1 = rs1;
        sbe[p].is_compressed = comp;
        target[p] = tgt;
        ack[p] = a;
    endtask

    task automatic call_ev(int p, logic [31:0] a_pc, logic comp);
        exp_t e;
        drive(p, CTRL_FLOW, JAL, 5'd1, 5'd0, a_pc, comp, 32'h0, 1'b1);
        e.kind = 2'b01;
        e.pc = a_pc;
        e.addr = a_pc + (comp ? 32'd2 : 32'd4);
        sb.push_back(e);
    endtask

    task automatic ret_ev(int p, logic [31:0] a_pc, logic [31:0] tgt);
        exp_t e;
        drive(p, CTRL_FLOW, JALR, 5'd0, 5'd5, a_pc, 1'b0, tgt, 1'b1);
        e.kind = 2'b10;
        e.pc = a_pc;
        e.addr = tgt;
        sb.push_back(e);
    endtask

    task automatic head_chk(string tag);
        chk({tag, "_valid"}, valid, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            chk({tag, "_kind"}, kind, sb[0].kind);
            chk({tag, "_pc"}, pc, sb[0].pc);
            chk({tag, "_addr"}, addr, sb[0].addr);
        end
    endtask

    task automatic pop_check(string tag);
        head_chk(tag);
        ready = 1'b1;
        step();
        ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        int sent;
        int cyc;
        bit popped;
        ack = '0;
        sbe = '0;
        target = '0;
        ready = 1'b0;

        // T1: reset state then a single CALL
        #3;
        chk("rst_valid", valid, 1'b0);
        chk("rst_wait", wait_o, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_kind", kind, 2'b00);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        call_ev(0, 32'h8000_0000, 1'b0);
        #1;
        chk("t1_no_bypass", valid, 1'b0);
        step();
        chk("t1_kind_exact", kind, 2'b01);
        chk("t1_addr_exact", addr, 32'h8000_0004);
        pop_check("t1");
        chk("t1_empty", valid, 1'b0);

        // T2: compressed call and return in one bundle
        drive(0, CTRL_FLOW, JALR, 5'd1, 5'd6, 32'h100, 1'b1, 32'h0, 1'b1);
        sb.push_back('{kind: 2'b01, pc: 32'h100, addr: 32'h102});
        drive(1, CTRL_FLOW, JALR, 5'd0, 5'd1, 32'h200, 1'b0, 32'h102, 1'b1);
        sb.push_back('{kind: 2'b10, pc: 32'h200, addr: 32'h102});
        step();
        pop_check("t2_call");
        pop_check("t2_ret");
        chk("t2_empty", valid, 1'b0);

        // T3: nothing classifiable
        drive(0, ALU, ADD, 5'd1, 5'd1, 32'h300, 1'b0, 32'h0, 1'b1);
        drive(1, CTRL_FLOW, JALR, 5'd0, 5'd6, 32'h304, 1'b0, 32'h40, 1'b1);
        step();
        chk("t3_valid_a", valid, 1'b0);
        drive(0, CTRL_FLOW, JAL, 5'd1, 5'd0, 32'h308, 1'b0, 32'h0, 1'b0);
        step();
        chk("t3_valid_b", valid, 1'b0);

        // T4: stall threshold
        for (int i = 0; i < 3; i++) begin
            call_ev(0, 32'h1000 + 32'(i * 16), 1'b0);
            ret_ev(1, 32'h1008 + 32'(i * 16), 32'h2000 + 32'(i));
            step();
        end
        chk("t4_wait_c6", wait_o, 1'b0);
        call_ev(0, 32'h1100, 1'b1);
        step();
        chk("t4_wait_c7", wait_o, 1'b1);
        pop_check("t4_pop");
        chk("t4_wait_c6b", wait_o, 1'b0);

        // T5: simultaneous push and pop at count 7
        call_ev(1, 32'h1200, 1'b0);
        step();
        chk("t5_wait_c7", wait_o, 1'b1);
        head_chk("t5_head");
        ready = 1'b1;
        call_ev(0, 32'h1300, 1'b0);
        step();
        ready = 1'b0;
        void'(sb.pop_front());
        chk("t5_wait_still", wait_o, 1'b1);
        chk("t5_ovf", ovf, 1'b0);

        // T6: overflow drops the higher port
        call_ev(0, 32'h1400, 1'b0);
        drive(1, CTRL_FLOW, JAL, 5'd5, 5'd0, 32'h1404, 1'b0, 32'h0, 1'b1);
        step();
        chk("t6_ovf", ovf, 1'b1);
        chk("t6_wait_full", wait_o, 1'b1);
        step();
        chk("t6_ovf_sticky", ovf, 1'b1);
        for (int i = 0; i < D; i++) pop_check("t6_drain");
        chk("t6_drained", valid, 1'b0);
        chk("t6_ovf_hold", ovf, 1'b1);
        call_ev(0, 32'h1500, 1'b0);
        call_ev(1, 32'h1504, 1'b1);
        step();
        chk("t6_refill", valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_ovf", ovf, 1'b0);
        chk("t6_rst_kind", kind, 2'b00);
        chk("t6_rst_wait", wait_o, 1'b0);
        sb.delete();
        #3;
        rst_n = 1'b1;
        step();

        // T7: random ready, 3*DEPTH events across pointer wrap
        sent = 0;
        cyc = 0;
        while ((sent < 3 * D || sb.size() != 0) && cyc < 3000) begin
            chk("t7_valid", valid, sb.size() != 0);
            popped = 1'b0;
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                head_chk("t7_head");
                popped = 1'b1;
            end
            if (sent < 3 * D && !wait_o) begin
                for (int p = 0; p < P; p++) begin
                    if (sent < 3 * D && $urandom_range(0, 2) != 0) begin
                        if ($urandom_range(0, 1) == 0)
                            call_ev(p, $urandom, 1'($urandom_range(0, 1)));
                        else
                            ret_ev(p, $urandom, $urandom);
                        sent++;
                    end
                end
            end
            step();
            ready = 1'b0;
            if (popped) void'(sb.pop_front());
            cyc++;
        end
        chk("t7_drained", sb.size(), 0);
        chk("t7_done_valid", valid, 1'b0);
        chk("t7_ovf", ovf, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
